// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - triggered sample capture into a circular buffer
// Writes decimated samples with pre-trigger history and reports the trigger address.
module trigger_capture #(
   parameter int BITS_ADC  = 8,
   parameter int BITS_ADDR = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BITS_ADC-1:0]  trig_level,
   input  logic                 trig_edge,
   input  logic                 trig_force,
   input  logic [BITS_ADDR-1:0] pretrig_len,
   input  logic [BITS_ADC-1:0]  sample_in,
   input  logic                 rdy_in,
   output logic                 wr_en,
   output logic [BITS_ADDR-1:0] wr_addr,
   output logic [BITS_ADC-1:0]  wr_data,
   output logic [BITS_ADDR-1:0] trig_addr,
   output logic                 triggered,
   output logic                 busy,
   output logic                 done
);

   localparam int DEPTH = 1 << BITS_ADDR;
   localparam logic [BITS_ADDR:0]   DEPTH_W = (BITS_ADDR+1)'(DEPTH);
   localparam logic [BITS_ADDR:0]   ONE_W   = (BITS_ADDR+1)'(1);
   localparam logic [BITS_ADDR-1:0] ONE_A   = BITS_ADDR'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT,
      S_POST,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [BITS_ADDR-1:0] addr;
   logic [BITS_ADC-1:0]  prev;
   logic                 prev_valid;
   logic                 force_pend;
   logic [BITS_ADC-1:0]  level_q;
   logic                 edge_q;
   logic [BITS_ADDR-1:0] pre_q;
   logic [BITS_ADDR:0]   post_cnt;

   logic [BITS_ADDR:0]   post_len;
   logic [BITS_ADDR:0]   post_next;
   logic                 accept;
   logic                 rise_hit;
   logic                 fall_hit;
   logic                 level_hit;
   logic                 trig_hit;

   // Trigger decode; start masks acceptance so a coincident sample is dropped.
   always_comb begin
      post_len  = DEPTH_W - {1'b0, pre_q};
      post_next = post_cnt + ONE_W;
      accept    = rdy_in && !start &&
                  (state == S_PRE || state == S_WAIT || state == S_POST);
      rise_hit  = prev_valid && (prev < level_q) && (sample_in >= level_q);
      fall_hit  = prev_valid && (prev > level_q) && (sample_in <= level_q);
      level_hit = edge_q ? fall_hit : rise_hit;
      trig_hit  = accept && (state == S_WAIT) &&
                  (level_hit || force_pend || trig_force);
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      if (start) begin
         state_nxt = (pretrig_len == '0) ? S_WAIT : S_PRE;
      end else begin
         case (state)
            S_PRE: begin
               if (accept && (addr == pre_q - ONE_A)) state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (trig_hit) state_nxt = (post_len > ONE_W) ? S_POST : S_DONE;
            end
            S_POST: begin
               if (accept && (post_next == post_len)) state_nxt = S_DONE;
            end
            default: state_nxt = state;
         endcase
      end
      case (state)
         S_PRE, S_WAIT, S_POST: busy = 1'b1;
         S_DONE:                done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr       <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         force_pend <= 1'b0;
         level_q    <= '0;
         edge_q     <= 1'b0;
         pre_q      <= '0;
         post_cnt   <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         trig_addr  <= '0;
         triggered  <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         triggered <= 1'b0;
         if (start) begin
            addr       <= '0;
            prev_valid <= 1'b0;
            force_pend <= 1'b0;
            level_q    <= trig_level;
            edge_q     <= trig_edge;
            pre_q      <= pretrig_len;
            post_cnt   <= '0;
            trig_addr  <= '0;
         end else begin
            if (accept) begin
               wr_en      <= 1'b1;
               wr_addr    <= addr;
               wr_data    <= sample_in;
               addr       <= addr + ONE_A;
               prev       <= sample_in;
               prev_valid <= 1'b1;
            end
            // The trigger sample is post-sample 1 of the post-trigger run.
            if (trig_hit) begin
               triggered  <= 1'b1;
               trig_addr  <= addr;
               post_cnt   <= ONE_W;
               force_pend <= 1'b0;
            end else if (state == S_WAIT && trig_force) begin
               force_pend <= 1'b1;
            end
            if (state == S_POST && accept) post_cnt <= post_next;
         end
      end
   end

endmodule
